// File: rtl/fpu_to_int.sv
// fpu_to_int: converts a 32-bit FPU word (1/11/20) to a signed 32-bit integer.
// Rounding is toward zero. A multi-cycle FSM shifts the significand one bit per cycle.
// A valid/ready handshake is used on both the input side and the output side.
module fpu_to_int #(
  parameter int unsigned BIAS = 1023
) (
  input  logic        clock_100k,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic [3:0]  status_out
);

  localparam int unsigned DW = 32;  // data / integer width
  localparam int unsigned EW = 11;  // exponent width
  localparam int unsigned FW = 20;  // fraction width
  localparam int unsigned CW = 5;   // shift counter width (max count 20)
  localparam int unsigned XW = 13;  // signed unbiased exponent width

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SHIFT,
    S_SIGN,
    S_OUTPUT
  } state_t;

  typedef enum logic [2:0] {
    C_NORM,    // finite value needing a shift
    C_ZERO,    // e == 0, signed zero
    C_UNDER,   // |value| < 1
    C_OVER,    // saturating overflow
    C_MININT   // exactly -2^31, representable
  } cls_t;

  state_t              r_state, w_state_nxt;
  cls_t                r_cls, w_cls_nxt;
  logic [DW-1:0]       r_fp, w_fp_nxt;
  logic [DW-1:0]       r_mag, w_mag_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_left, w_left_nxt;
  logic                r_sticky, w_sticky_nxt;
  logic [DW-1:0]       r_int, w_int_nxt;
  logic [3:0]          r_status, w_status_nxt;
  logic                r_in_ready, w_in_ready_nxt;
  logic                r_out_valid, w_out_valid_nxt;

  logic                w_sign;
  logic [EW-1:0]       w_exp;
  logic [FW-1:0]       w_frac;
  logic signed [XW-1:0] w_e_unb;
  logic [2:0]          w_flags;

  assign w_sign  = r_fp[31];
  assign w_exp   = r_fp[30:20];
  assign w_frac  = r_fp[19:0];
  assign w_e_unb = $signed({2'b00, w_exp}) - $signed(XW'(BIAS));

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign int_out    = r_int;
  assign status_out = r_status;

  // Next-state and datapath update for every register.
  always_comb begin
    w_state_nxt  = r_state;
    w_cls_nxt    = r_cls;
    w_fp_nxt     = r_fp;
    w_mag_nxt    = r_mag;
    w_cnt_nxt    = r_cnt;
    w_left_nxt   = r_left;
    w_sticky_nxt = r_sticky;
    w_int_nxt    = r_int;
    w_status_nxt = r_status;
    w_flags      = 3'b000;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_fp_nxt    = fp_in;
          w_state_nxt = S_UNPACK;
        end
      end

      S_UNPACK: begin
        w_mag_nxt    = {(DW-FW-1)'(0), 1'b1, w_frac};
        w_sticky_nxt = 1'b0;
        w_cls_nxt    = C_NORM;
        w_left_nxt   = 1'b0;
        w_cnt_nxt    = '0;
        w_state_nxt  = S_SIGN;
        if (w_exp == '0) begin
          w_cls_nxt = C_ZERO;
        end else if (w_exp == '1) begin
          w_cls_nxt = C_OVER;
        end else if (w_e_unb < 13'sd0) begin
          w_cls_nxt = C_UNDER;
        end else if (w_e_unb > 13'sd30) begin
          // -2^31 itself fits; anything else at this magnitude saturates
          if (w_sign && (w_e_unb == 13'sd31) && (w_frac == '0)) begin
            w_cls_nxt = C_MININT;
          end else begin
            w_cls_nxt = C_OVER;
          end
        end else if (w_e_unb < 13'sd20) begin
          w_cnt_nxt   = CW'(13'sd20 - w_e_unb);
          w_state_nxt = S_SHIFT;
        end else begin
          w_left_nxt  = 1'b1;
          w_cnt_nxt   = CW'(w_e_unb - 13'sd20);
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // One bit per cycle; right shifts collect lost bits into sticky
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_left) begin
            w_mag_nxt = r_mag << 1;
          end else begin
            w_mag_nxt    = r_mag >> 1;
            w_sticky_nxt = r_sticky | r_mag[0];
          end
        end
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_SIGN;
        end
      end

      S_SIGN: begin
        case (r_cls)
          C_ZERO: begin
            w_int_nxt = '0;
            w_flags   = 3'b000;
          end
          C_UNDER: begin
            w_int_nxt = '0;
            w_flags   = 3'b011;
          end
          C_OVER: begin
            w_int_nxt = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            w_flags   = 3'b100;
          end
          C_MININT: begin
            w_int_nxt = 32'h8000_0000;
            w_flags   = 3'b000;
          end
          default: begin
            w_int_nxt = w_sign ? (~r_mag + 32'd1) : r_mag;
            w_flags   = {2'b00, r_sticky};
          end
        endcase
        w_status_nxt = {~|w_flags, w_flags};
        w_state_nxt  = S_OUTPUT;
      end

      S_OUTPUT: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // out_valid rises one cycle after entering OUTPUT, drops on the handshake
    w_out_valid_nxt = (r_state == S_OUTPUT) && (w_state_nxt == S_OUTPUT);
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cls       <= C_NORM;
      r_fp        <= '0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_left      <= 1'b0;
      r_sticky    <= 1'b0;
      r_int       <= '0;
      r_status    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cls       <= w_cls_nxt;
      r_fp        <= w_fp_nxt;
      r_mag       <= w_mag_nxt;
      r_cnt       <= w_cnt_nxt;
      r_left      <= w_left_nxt;
      r_sticky    <= w_sticky_nxt;
      r_int       <= w_int_nxt;
      r_status    <= w_status_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: doc/fpu_to_int.md
FPU_TO_INT -- requirements
Module: fpu_to_int

Interface
REQ-001 SHALL have parameter: BIAS, 1023, exponent bias of the FPU word format.
REQ-002 SHALL have port: clock_100k  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  fp_in is valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts fp_in this cycle.
REQ-006 SHALL have port: fp_in  input  32  FPU word: sign [31], exponent [30:20], fraction [19:0].
REQ-007 SHALL have port: out_valid  output  1  int_out/status_out hold a result.
REQ-008 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port: int_out  output  32  signed two's-complement result.
REQ-010 SHALL have port: status_out  output  4  [3] exact, [2] overflow, [1] underflow, [0] inexact.

Function
REQ-011 SHALL decode value = (-1)^s * 1.f * 2^(e-BIAS) for e in 1..2046, with the hidden one prepended to form a 21-bit significand.
REQ-012 SHALL treat e=0 as signed zero (fraction ignored): int_out 0, status 4'b1000.
REQ-013 SHALL treat e=2047 as overflow: saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1), status 4'b0100.
REQ-014 SHALL round toward zero (truncate) and set inexact when any discarded significand bit is 1.
REQ-015 SHALL, with E=e-BIAS: E<0 -> int_out 0, status 4'b0011; 0<=E<=19 -> shift significand right 20-E; 20<=E<=30 -> shift left E-20; E>=31 -> overflow per REQ-013, except s=1, E=31, f=0 -> 0x80000000, status 4'b1000.
REQ-016 SHALL set exact (bit 3) exactly when overflow, underflow and inexact are all 0.
REQ-017 SHALL implement FSM IDLE -> UNPACK -> SHIFT -> SIGN -> OUTPUT -> IDLE.
REQ-018 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid and in_ready are both 1, and fp_in SHALL be registered on that edge.
REQ-019 SHALL in UNPACK compute E, the shift direction and the shift count (1 cycle), classifying special cases; special cases (REQ-012, REQ-013, E<0, E>=31) SHALL go directly to SIGN.
REQ-020 SHALL in SHIFT move the significand one bit per cycle, decrement a count, and OR bits shifted out into a sticky bit; it SHALL exit to SIGN when the count is 0 (a zero count spends 1 cycle in SHIFT).
REQ-021 SHALL in SIGN two's-complement negate the magnitude when s=1 and form status_out (1 cycle).
REQ-022 SHALL in OUTPUT hold out_valid=1 with int_out/status_out stable until out_ready=1, then return to IDLE on that edge.
REQ-023 SHALL have a latency from the accept edge to out_valid of 3+max(N,1) cycles for normal inputs (N = shift count; max 20 right, 10 left) and 3 cycles for special cases.
REQ-024 SHALL ignore in_valid outside IDLE; there is no back-to-back accept in the cycle out_ready completes.

Reset
REQ-025 SHALL, while reset=1, force the state to IDLE, in_ready=1, out_valid=0, int_out=0, status_out=0, and clear all internal registers, independent of the clock.
REQ-026 SHALL abandon any in-flight conversion when reset asserts mid-operation, with no result emitted after release.

Verification
REQ-027 SHALL cover: fp_in=0x3FF00000 (1.0) -> int_out=0x00000001, status=4'b1000, out_valid 23 cycles after accept.
REQ-028 SHALL cover: fp_in=0x400C0000 (3.5) -> int_out=0x00000003, status=4'b0001; fp_in=0x3FE00000 (0.5) -> int_out=0, status=4'b0011.
REQ-029 SHALL cover: fp_in=0xC0900000 (-1024) -> int_out=0xFFFFFC00, status=4'b1000.
REQ-030 SHALL cover: fp_in=0x41E00000 (+2^31) -> 0x7FFFFFFF, status=4'b0100; fp_in=0xC1E00000 (-2^31) -> 0x80000000, status=4'b1000; fp_in=0x7FF00000 -> 0x7FFFFFFF, status=4'b0100.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles -> out_valid and outputs stable, in_ready=0, a new in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-032 SHALL cover: reset pulsed during SHIFT of 0x3FF00000 -> all outputs 0, in_ready=1 immediately, no out_valid after release; the next conversion is correct.
